jacobi_sincos: RTL and testbench
================================

# jacobi_sincos

Stage 2 of the CORDIC engine. It sits directly downstream of the stage-1 arctangent unit. It takes the 8-bit doubled rotation angle 2θ, halves it, and runs an iterative rotation-mode CORDIC to produce cos θ and sin θ. The results are handed to the Jacobi rotation stage through a valid/ready handshake. The upstream arctangent unit cannot be stalled, so the block buffers up to two pending angles internally.

## Interface
Parameters:
- ITER, 12: CORDIC micro-rotations per angle. Legal range is 8..14.
- IW, 16: internal datapath width for x, y and z.

Ports:
- clk, input, 1: the single clock. All logic is on the rising edge.
- rst_n, input, 1: asynchronous, active-low reset.
- in_valid, input, 1: a 2θ sample is present. There is no ready; the sample is accepted unconditionally.
- in_angle, input, 8: 2θ in radians, signed Fix8_5, range [-π, π].
- out_valid, output, 1: cos/sin results are valid.
- out_ready, input, 1: the downstream stage accepts the results.
- out_cos, output, 8: cos θ, signed Fix8_6.
- out_sin, output, 8: sin θ, signed Fix8_6.
- busy, output, 1: asserted whenever the FSM is not in IDLE.
- overflow, output, 1: sticky flag. Set when a sample arrives while the FIFO is full. Cleared only by reset.

## Operation
- Input FIFO, 2 deep:
  - Write: in_valid writes in_angle.
  - Pop: the FSM pops one entry in IDLE when the FIFO is non-empty.
  - Simultaneous write and pop when full: allowed, no overflow.
  - Write while full with no pop in the same cycle: the sample is dropped and overflow is set.
- Angle conversion:
  - z0 = sign_extend(in_angle) <<< 7. This maps Fix8_5 to the internal Fix16_13 format and halves the angle at the same time.
  - The resulting θ lies in [-π/2, π/2], which is inside the CORDIC convergence range.
- Initial values:
  - x0 = K_INV = 9949, i.e. 0.607253 in Fix16_14.
  - y0 = 0.
- Iteration i (0..ITER-1), with d = (z ≥ 0) ? +1 : −1:
  - x' = x − d·(y >>> i)
  - y' = y + d·(x >>> i)
  - z' = z − d·ATAN[i]
  - ATAN[i] = round(atan(2^-i)·8192).
  - All shifts are arithmetic. Arithmetic wraps at IW bits; no saturation is needed inside the loop.
- FSM states:
  - IDLE: if the FIFO is non-empty, pop, load x/y/z, clear the iteration counter, go to ITER.
  - ITER: perform one micro-rotation per cycle. When the counter reaches ITER-1, go to DONE.
  - DONE: hold out_valid = 1. On out_valid && out_ready, go to IDLE.
- Output format, default (truncate):
  - out_cos = x[15:8] and out_sin = y[15:8], i.e. Fix16_14 to Fix8_6 by dropping 8 LSBs.
- Output stability: out_cos and out_sin are registered and stay stable while out_valid && !out_ready.

## Timing
- Reset values: out_valid 0, out_cos 0, out_sin 0, busy 0, overflow 0, FIFO empty, FSM in IDLE.
- Latency with an empty FIFO and an idle FSM:
  - Sample at edge N is written to the FIFO.
  - Edge N+1: pop and load.
  - Edges N+2 .. N+ITER+1: iterations.
  - out_valid is high after edge N+ITER+1, i.e. 13 cycles after sampling with ITER=12.
- Throughput: one angle per ITER+2 cycles when out_ready is held high. The DONE→IDLE→load sequence costs 2 cycles.
- Back-to-back samples: 4 consecutive in_valid cycles while idle leave samples 2 and 3 in the FIFO and drop sample 4. Overflow rises after that edge.
- Reset mid-operation: on rst_n low, all state clears immediately. In-flight and buffered angles are discarded, and no partial result is ever presented.

## Configuration
- SINCOS_ROUND_EN:
  - Defined: the output uses round-half-up, adding 0x80 before taking [15:8], and saturates positive overflow to 127. Example: cos(0) stays at 64.
  - Undefined: plain truncation as described in Operation.
  - Latency is identical in both builds.

## Structure
- Package pca_cordic_pkg holds:
  - ANGLE_W = 8 and TRIG_W = 8
  - IW and ITER defaults
  - K_INV
  - the ATAN lookup constant array of 14 entries in Fix16_13
  - the FSM state enum typedef {IDLE, ITER, DONE}
- Sub-module sincos_in_fifo: the 2-deep FIFO with full/empty and overflow detection.
- The CORDIC datapath and FSM stay in jacobi_sincos.

## Test plan
- Zero angle: in_angle = 0 → out_cos = 64 (±1), out_sin = 0 (±1), out_valid 13 cycles after the sample.
- Positive angle: in_angle = 50 (2θ ≈ π/2) → out_cos = 45 ±1, out_sin = 45 ±1. Negative angle: in_angle = −50 → out_cos = 45 ±1, out_sin = −45 ±1.
- Near-limit angle: in_angle = 100 (θ ≈ 1.5625 rad) → out_cos ∈ {0, 1}, out_sin ∈ {63, 64}. With SINCOS_ROUND_EN defined: in_angle = 0 → out_cos exactly 64.
- Backpressure: hold out_ready = 0 for 20 cycles after out_valid rises → outputs stay stable, busy = 1. Then raise out_ready → exactly one transfer happens, and the next FIFO entry loads on the following cycle.
- Overflow: 4 back-to-back in_valid pulses with values 0, 50, −50, 100 → three results are delivered in order (0, 50, −50), overflow = 1, and 100 is never output.
- Reset mid-iteration: deassert rst_n 5 cycles after a sample → all outputs return to their reset values. After release, a new sample produces a correct result with normal latency.

Source files
------------

// File: rtl/pca_cordic_pkg.sv
// pca_cordic_pkg -- shared constants and types for the CORDIC sin/cos stage.
//   ANGLE_W / TRIG_W : widths of the 2-theta input and the cos/sin outputs
//   IW_DEF / ITER_DEF: default datapath width and micro-rotation count
//   K_INV            : CORDIC gain compensation, 0.607253 in Fix16_14
//   ATAN_LUT         : round(atan(2^-i) * 8192), Fix16_13, i = 0..13
//   cordic_state_e   : FSM states (ST_ prefix keeps ST_ITER clear of the
//                      ITER parameter in the modules that import this)
package pca_cordic_pkg;

  localparam int ANGLE_W  = 8;
  localparam int TRIG_W   = 8;
  localparam int IW_DEF   = 16;
  localparam int ITER_DEF = 12;
  localparam int ITER_MAX = 14;

  localparam logic signed [15:0] K_INV = 16'sd9949;

  localparam logic signed [15:0] ATAN_LUT [ITER_MAX] = '{
    16'sd6434, 16'sd3798, 16'sd2007, 16'sd1019, 16'sd511, 16'sd256, 16'sd128,
    16'sd64,   16'sd32,   16'sd16,   16'sd8,    16'sd4,   16'sd2,   16'sd1
  };

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ITER = 2'd1,
    ST_DONE = 2'd2
  } cordic_state_e;

endpackage

// File: rtl/sincos_in_fifo.sv
// sincos_in_fifo -- 2-deep angle buffer in front of the CORDIC engine.
// The upstream unit cannot be stalled, so writes are unconditional; a write
// that finds the buffer full (with no pop in the same cycle) is dropped and
// sets a sticky overflow flag.
// Ports:
//   clk, rst_n        : clock, asynchronous active-low reset
//   wr_en, wr_data    : push request and angle
//   rd_en             : pop request (ignored when empty)
//   rd_data           : head entry (valid when !empty)
//   empty, full       : occupancy flags
//   overflow          : sticky, cleared only by reset
module sincos_in_fifo
  import pca_cordic_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [ANGLE_W-1:0] wr_data,
  input  logic               rd_en,
  output logic [ANGLE_W-1:0] rd_data,
  output logic               empty,
  output logic               full,
  output logic               overflow
);

  logic [ANGLE_W-1:0] mem_reg [2];
  logic               wr_ptr_reg;
  logic               rd_ptr_reg;
  logic [1:0]         count_reg;
  logic [1:0]         count_next;
  logic               overflow_reg;
  logic               do_pop;
  logic               do_push;

  assign empty    = (count_reg == 2'd0);
  assign full     = (count_reg == 2'd2);
  assign rd_data  = mem_reg[rd_ptr_reg];
  assign overflow = overflow_reg;

  assign do_pop  = rd_en && !empty;
  // When full, a same-cycle pop frees the slot the write pointer aims at;
  // the popped value is read combinationally before the edge overwrites it.
  assign do_push = wr_en && (!full || do_pop);

  always_comb begin
    count_next = count_reg;
    case ({do_push, do_pop})
      2'b10:   count_next = count_reg + 2'd1;
      2'b01:   count_next = count_reg - 2'd1;
      default: count_next = count_reg;
    endcase
  end

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_mem
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          mem_reg[gi] <= '0;
        end else if (do_push && (wr_ptr_reg == 1'(gi))) begin
          mem_reg[gi] <= wr_data;
        end
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_reg   <= 1'b0;
      rd_ptr_reg   <= 1'b0;
      count_reg    <= 2'd0;
      overflow_reg <= 1'b0;
    end else begin
      count_reg <= count_next;
      if (do_push) wr_ptr_reg <= ~wr_ptr_reg;
      if (do_pop)  rd_ptr_reg <= ~rd_ptr_reg;
      if (wr_en && full && !do_pop) overflow_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/jacobi_sincos.sv
// jacobi_sincos -- iterative rotation-mode CORDIC producing cos/sin of theta
// from the doubled angle 2*theta (Fix8_5). Results leave on a valid/ready
// handshake and are held stable while the consumer stalls.
// Build option: SINCOS_ROUND_EN -- round-half-up with positive saturation on
// the Fix16_14 -> Fix8_6 output conversion (default build truncates).
// Ports:
//   clk, rst_n          : clock, asynchronous active-low reset
//   in_valid, in_angle  : 2*theta sample, always accepted (buffered 2 deep)
//   out_valid, out_ready: result handshake
//   out_cos, out_sin    : cos/sin of theta, signed Fix8_6
//   busy                : FSM is not idle
//   overflow            : sticky, a sample was dropped on a full buffer
module jacobi_sincos
  import pca_cordic_pkg::*;
#(
  parameter int ITER = ITER_DEF,
  parameter int IW   = IW_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  input  logic [ANGLE_W-1:0] in_angle,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [TRIG_W-1:0]  out_cos,
  output logic [TRIG_W-1:0]  out_sin,
  output logic               busy,
  output logic               overflow
);

  localparam int CW = $clog2(ITER_MAX + 1);

  cordic_state_e state_reg, state_next;

  logic [ANGLE_W-1:0] fifo_data;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               step;
  logic               last;

  logic signed [IW-1:0] x_reg, y_reg, z_reg;
  logic signed [IW-1:0] x_it, y_it, z_it;
  logic signed [IW-1:0] x_sh, y_sh, atan_val, z_load;
  logic [CW-1:0]        iter_cnt_reg;
  logic [TRIG_W-1:0]    out_cos_reg, out_sin_reg;
  logic [TRIG_W-1:0]    fmt_res [2];

  sincos_in_fifo u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (in_valid),
    .wr_data  (in_angle),
    .rd_en    (pop),
    .rd_data  (fifo_data),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .overflow (overflow)
  );

  // Fix8_5 -> Fix16_13 needs <<< 8; shifting by 7 also halves 2*theta.
  assign z_load = $signed({{(IW-ANGLE_W){fifo_data[ANGLE_W-1]}}, fifo_data}) <<< 7;

  assign x_sh     = x_reg >>> iter_cnt_reg;
  assign y_sh     = y_reg >>> iter_cnt_reg;
  assign atan_val = IW'(ATAN_LUT[iter_cnt_reg]);

  // One micro-rotation; direction follows the sign of the residual angle.
  always_comb begin
    x_it = x_reg;
    y_it = y_reg;
    z_it = z_reg;
    if (!z_reg[IW-1]) begin
      x_it = x_reg - y_sh;
      y_it = y_reg + x_sh;
      z_it = z_reg - atan_val;
    end else begin
      x_it = x_reg + y_sh;
      y_it = y_reg - x_sh;
      z_it = z_reg + atan_val;
    end
  end

  // Output conversion of the final rotation result: index 0 = cos, 1 = sin.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_fmt
`ifdef SINCOS_ROUND_EN
      logic [TRIG_W:0] rnd_sum;
      // Adding the first dropped bit to the kept bits equals adding half an
      // output LSB before truncation; the extra MSB catches +max wrap.
      assign rnd_sum = (gi == 0)
        ? ({x_it[IW-1], x_it[IW-1 -: TRIG_W]} + (TRIG_W+1)'(x_it[IW-TRIG_W-1]))
        : ({y_it[IW-1], y_it[IW-1 -: TRIG_W]} + (TRIG_W+1)'(y_it[IW-TRIG_W-1]));
      assign fmt_res[gi] = (rnd_sum[TRIG_W] != rnd_sum[TRIG_W-1])
        ? {1'b0, {(TRIG_W-1){1'b1}}}
        : rnd_sum[TRIG_W-1:0];
`else
      assign fmt_res[gi] = (gi == 0) ? x_it[IW-1 -: TRIG_W] : y_it[IW-1 -: TRIG_W];
`endif
    end
  endgenerate

  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    step       = 1'b0;
    last       = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop        = 1'b1;
          state_next = ST_ITER;
        end
      end
      ST_ITER: begin
        step = 1'b1;
        if (iter_cnt_reg == CW'(ITER - 1)) begin
          last       = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_reg        <= '0;
      y_reg        <= '0;
      z_reg        <= '0;
      iter_cnt_reg <= '0;
      out_cos_reg  <= '0;
      out_sin_reg  <= '0;
    end else if (pop) begin
      x_reg        <= IW'(K_INV);
      y_reg        <= '0;
      z_reg        <= z_load;
      iter_cnt_reg <= '0;
    end else if (step) begin
      x_reg        <= x_it;
      y_reg        <= y_it;
      z_reg        <= z_it;
      iter_cnt_reg <= iter_cnt_reg + CW'(1);
      // Capture on the final rotation so the outputs are ready with DONE.
      if (last) begin
        out_cos_reg <= fmt_res[0];
        out_sin_reg <= fmt_res[1];
      end
    end
  end

  assign out_valid = (state_reg == ST_DONE);
  assign busy      = (state_reg != ST_IDLE);
  assign out_cos   = out_cos_reg;
  assign out_sin   = out_sin_reg;

endmodule

// File: tb/tb_jacobi_sincos.sv
`timescale 1ns/1ps
module tb_jacobi_sincos;

  localparam int ITER = 12;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] in_angle = '0;
  logic       out_ready = 1'b0;
  logic       out_valid;
  logic [7:0] out_cos;
  logic [7:0] out_sin;
  logic       busy;
  logic       overflow;

  always #5 clk = ~clk;

  jacobi_sincos #(.ITER(ITER), .IW(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_angle  (in_angle),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_cos   (out_cos),
    .out_sin   (out_sin),
    .busy      (busy),
    .overflow  (overflow)
  );

  typedef struct {
    int angle;
    int cos_e;
    int sin_e;
  } exp_t;

  exp_t sb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  // Ideal trig value quantised to Fix8_6 the way the output stage does.
  function automatic int model_q6(input real v);
    real s;
    int  r;
    s = v * 64.0;
`ifdef SINCOS_ROUND_EN
    r = int'($floor(s + 0.5));
    if (r > 127) r = 127;
`else
    r = int'($floor(s));
`endif
    return r;
  endfunction

  task automatic check(input string name, input int act, input int exp, input int tol);
    n_vec++;
    if (act > exp + tol || act < exp - tol) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (tol %0d)", name, act, exp, tol);
    end
  endtask

  task automatic push_exp(input int a);
    exp_t e;
    real  th;
    th      = a / 64.0;          // theta = (a/32)/2 radians
    e.angle = a;
    e.cos_e = model_q6($cos(th));
    e.sin_e = model_q6($sin(th));
    sb_q.push_back(e);
  endtask

  task automatic send(input int a, input bit accepted);
    in_angle = 8'(a);
    in_valid = 1'b1;
    if (accepted) push_exp(a);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_drain(input int max_cyc, input bit rand_ready);
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < max_cyc) begin
      out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk);
      #1;
      k++;
    end
    check("drain_pending", sb_q.size(), 0, 0);
  endtask

  task automatic latency_test(input int a, input string name);
    int k;
    out_ready = 1'b1;
    send(a, 1'b1);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check({name, "_latency"}, k, ITER + 1, 0);
    wait_drain(50, 1'b0);
  endtask

  // Scoreboard monitor: a transfer happens on the next rising edge.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      if (sb_q.size() == 0) begin
        check("unexpected_output", 1, 0, 0);
      end else begin
        e = sb_q.pop_front();
        $display("xfer angle=%0d cos=%0d (exp %0d) sin=%0d (exp %0d)",
                 e.angle, $signed(out_cos), e.cos_e, $signed(out_sin), e.sin_e);
        check("cos", int'($signed(out_cos)), e.cos_e, 1);
        check("sin", int'($signed(out_sin)), e.sin_e, 1);
      end
    end
  end

  initial begin : watchdog
    #500us;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    logic [7:0] hold_cos;
    logic [7:0] hold_sin;
    int         k;
    int         burst;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0, 0);
    check("rst_out_cos",   out_cos,   0, 0);
    check("rst_out_sin",   out_sin,   0, 0);
    check("rst_busy",      busy,      0, 0);
    check("rst_overflow",  overflow,  0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed angles with latency measurement
    latency_test(0,   "zero");
    latency_test(50,  "pos50");
    latency_test(-50, "neg50");
    latency_test(100, "pos100");

    // Backpressure: one result held, a second angle waiting in the buffer
    out_ready = 1'b0;
    send(30, 1'b1);
    send(-70, 1'b1);
    k = 0;
    while (!out_valid && k < 40) begin
      @(posedge clk);
      #1;
      k++;
    end
    check("bp_valid_seen", out_valid, 1, 0);
    hold_cos = out_cos;
    hold_sin = out_sin;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk);
      #1;
      check("bp_cos_stable", out_cos, hold_cos, 0);
      check("bp_sin_stable", out_sin, hold_sin, 0);
      check("bp_busy", busy, 1, 0);
      check("bp_valid_held", out_valid, 1, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    check("bp_one_transfer", sb_q.size(), 1, 0);
    check("bp_valid_dropped", out_valid, 0, 0);
    check("bp_idle_after_xfer", busy, 0, 0);
    @(posedge clk);
    #1;
    check("bp_next_loaded", busy, 1, 0);
    wait_drain(60, 1'b0);

    // Overflow: four back-to-back samples, the fourth is dropped
    out_ready = 1'b1;
    check("ovf_before", overflow, 0, 0);
    send(0, 1'b1);
    send(50, 1'b1);
    send(-50, 1'b1);
    check("ovf_three_in", overflow, 0, 0);
    send(100, 1'b0);
    check("ovf_set", overflow, 1, 0);
    wait_drain(80, 1'b0);
    repeat (30) @(posedge clk);
    #1;
    check("ovf_no_extra_valid", out_valid, 0, 0);
    check("ovf_sticky", overflow, 1, 0);

    // Reset in the middle of the iterations
    send(40, 1'b1);
    repeat (5) @(posedge clk);
    #1;
    check("mid_busy", busy, 1, 0);
    rst_n = 1'b0;
    sb_q.delete();
    #1;
    check("mid_rst_out_valid", out_valid, 0, 0);
    check("mid_rst_out_cos",   out_cos,   0, 0);
    check("mid_rst_out_sin",   out_sin,   0, 0);
    check("mid_rst_busy",      busy,      0, 0);
    check("mid_rst_overflow",  overflow,  0, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    latency_test(-20, "post_rst");

    // Randomized bursts of 1..3 samples (never enough to overflow)
    for (int r = 0; r < 40; r++) begin
      burst = int'($urandom_range(1, 3));
      for (int b = 0; b < burst; b++) begin
        send(int'($urandom_range(0, 200)) - 100, 1'b1);
      end
      wait_drain(400, 1'b1);
    end

    out_ready = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    check("final_idle", busy, 0, 0);
    check("final_overflow", overflow, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
